spi_master_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one byte-level SPI engine among `N_REQ` requesters. Each requester owns one slave-select line and issues single-byte or locked multi-byte bursts. The block sits between the requesters and the SPI byte engine, whose ports are `data_in`, `SPI_start`, `SPI_EN` and `data_out`. It drives the engine's start strobe and transmit byte, tracks the engine's busy window, returns each received byte to its owner, and enforces a chip-select gap between bursts. It also recovers from a stalled engine through a watchdog.

---
 rtl/spi_master_arbiter_if.sv | 32 +++
 rtl/spi_master_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_arbiter_if.sv
// Requester-side bus of spi_master_arbiter.
//   master modport : requester side (drives requests, sees ready/responses)
//   slave modport  : arbiter side (sees requests, drives ready/responses)
// Signals:
//   req_valid[i]               requester i has a byte pending
//   req_data[8*i+7:8*i]        byte for requester i
//   req_last[i]                pending byte ends requester i's burst
//   req_ready[i]               one-cycle pulse, byte i consumed
//   rsp_valid[i]               one-cycle pulse, rsp_data belongs to requester i
//   rsp_data                   received byte, shared
//   rsp_err                    qualifies rsp_valid, transfer timed out
interface spi_master_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_data;
    logic               rsp_err;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one byte-level SPI
// engine among N_REQ requesters, with locked bursts, chip-select gap and a
// watchdog on the engine busy handshake.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   req_if         requester bus (slave modport of spi_master_arbiter_if)
//   cs_n           active-low slave selects, at most one low
//   spi_start      one-cycle start strobe to the engine
//   spi_tx         transmit byte, stable while spi_start is high
//   spi_en         engine busy flag
//   spi_rx         engine received byte, valid first cycle spi_en is low
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | rotate-search req_valid from the pointer, select a winner
// START     | req_ready to owner, capture byte and last flag
// STROBE    | spi_start high for one cycle
// WAIT_BUSY | wait for spi_en to rise, START_TIMEOUT watchdog
// WAIT_DONE | wait for spi_en to fall, XFER_TIMEOUT watchdog
// HOLD      | burst lock, cs_n held, only the owner may continue
// GAP       | all cs_n high for GAP_CYCLES, then pointer = owner+1
module spi_master_arbiter #(
    parameter int N_REQ         = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 4,
    parameter int XFER_TIMEOUT  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_master_arbiter_if.slave  req_if,
    output logic [N_REQ-1:0]     cs_n,
    output logic                 spi_start,
    output logic [7:0]           spi_tx,
    input  logic                 spi_en,
    input  logic [7:0]           spi_rx
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int WDW  = $clog2(TMAX) + 1;
    localparam int GW   = $clog2(GAP_CYCLES) + 1;

    localparam logic [WDW-1:0] WD_START_LIM = WDW'(START_TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_XFER_LIM  = WDW'(XFER_TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_LOAD     = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0]  LAST_IDX     = PW'(N_REQ - 1);
    localparam logic [PW:0]    N_WIDE       = (PW+1)'(N_REQ);

    typedef enum logic [2:0] {
        IDLE, START, STROBE, WAIT_BUSY, WAIT_DONE, HOLD, GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               last_q, last_d;
    logic [7:0]         spi_tx_q, spi_tx_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [N_REQ-1:0]   cs_n_q, cs_n_d;

    logic               found;
    logic [PW-1:0]      win;
    logic [WDW-1:0]     wd_inc;
    logic               err_exit;
    logic [N_REQ-1:0]   req_ready_c;

    // Rotating-priority search: first requester at or after the pointer.
    always_comb begin
        logic [PW:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (!found && req_if.req_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    // Watchdog saturates so a long stall can never wrap into a false pass.
    assign wd_inc = (wd_q == '1) ? wd_q : wd_q + WDW'(1);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        spi_tx_d    = spi_tx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        wd_d        = wd_q;
        gap_d       = gap_q;
        cs_n_d      = cs_n_q;
        err_exit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d      = win;
                    cs_n_d       = '1;
                    cs_n_d[win]  = 1'b0;
                    state_d      = START;
                end
            end
            START: begin
                spi_tx_d = req_if.req_data[{owner_q, 3'b000} +: 8];
                last_d   = req_if.req_last[owner_q];
                state_d  = STROBE;
            end
            STROBE: begin
                wd_d    = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (spi_en) begin
                    wd_d    = '0;
                    state_d = WAIT_DONE;
                end else if (wd_q == WD_START_LIM) begin
                    err_exit = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            WAIT_DONE: begin
                if (!spi_en) begin
                    rsp_data_d           = spi_rx;
                    rsp_valid_d[owner_q] = 1'b1;
                    if (last_q) begin
                        cs_n_d  = '1;
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (wd_q == WD_XFER_LIM) begin
                    err_exit = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            HOLD: begin
                if (req_if.req_valid[owner_q]) begin
                    state_d = START;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                cs_n_d  = '1;
                state_d = IDLE;
            end
        endcase

        // Timeout aborts the burst regardless of last.
        if (err_exit) begin
            rsp_valid_d          = '0;
            rsp_valid_d[owner_q] = 1'b1;
            rsp_err_d            = 1'b1;
            rsp_data_d           = '0;
            cs_n_d               = '1;
            gap_d                = GAP_LOAD;
            state_d              = GAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            last_q      <= 1'b0;
            spi_tx_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            wd_q        <= '0;
            gap_q       <= '0;
            cs_n_q      <= '1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            spi_tx_q    <= spi_tx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            cs_n_q      <= cs_n_d;
        end
    end

    always_comb begin
        req_ready_c = '0;
        if (state_q == START) begin
            req_ready_c[owner_q] = 1'b1;
        end
    end

    assign req_if.req_ready = req_ready_c;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_data  = rsp_data_q;
    assign req_if.rsp_err   = rsp_err_q;
    assign cs_n             = cs_n_q;
    assign spi_start        = (state_q == STROBE);
    assign spi_tx           = spi_tx_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter. Requesters are fed from per-line
// byte queues; a small engine model answers each strobe with rx = tx ^ 0x99
// (so 0xA5 returns 0x3C), or never goes busy, or sticks busy.
module tb_spi_master_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] cs_n;
    logic         spi_start;
    logic [7:0]   spi_tx;
    logic         spi_en = 1'b0;
    logic [7:0]   spi_rx = 8'h00;
    int           eng_mode = 0;   // 0 normal, 1 never busy, 2 stuck busy

    always #5 clk = ~clk;

    spi_master_arbiter_if #(.N_REQ(N)) bus ();

    spi_master_arbiter #(
        .N_REQ(N), .GAP_CYCLES(2), .START_TIMEOUT(4), .XFER_TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (bus),
        .cs_n      (cs_n),
        .spi_start (spi_start),
        .spi_tx    (spi_tx),
        .spi_en    (spi_en),
        .spi_rx    (spi_rx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qi(int q[$], int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // ---------------- requester driver ----------------
    logic [8:0] rq [N][$];   // {last, data}; written by main only
    int         rd [N];      // read pointers; written by driver only

    task automatic push(int r, logic [7:0] d, logic l);
        rq[r].push_back({l, d});
    endtask

    initial begin
        logic [N-1:0] rdy;
        logic [8:0]   item;
        for (int i = 0; i < N; i++) rd[i] = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i] && rd[i] < rq[i].size()) rd[i]++;
                if (rd[i] < rq[i].size()) begin
                    item = rq[i][rd[i]];
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[8*i +: 8] = item[7:0];
                    bus.req_last[i]        = item[8];
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                    bus.req_last[i]        = 1'b0;
                end
            end
        end
    end

    // ---------------- engine model ----------------
    initial begin
        logic [7:0] tx;
        forever begin
            @(negedge clk);
            if (rst_n && spi_start) begin
                tx = spi_tx;
                if (eng_mode == 0) begin
                    @(posedge clk); #1 spi_en = 1'b1;
                    repeat (3) @(posedge clk);
                    #1 spi_en = 1'b0;
                    spi_rx = tx ^ 8'h99;
                end else if (eng_mode == 2) begin
                    @(posedge clk); #1 spi_en = 1'b1;
                    while (eng_mode == 2) @(posedge clk);
                    #1 spi_en = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int grant_q[$], grant_cyc[$], tx_q[$], start_cyc[$];
    int rsp_idx[$], rsp_dat[$], rsp_er[$], rsp_cyc[$], rsp_cs[$], gap_runs[$];
    int cs_falls [N];
    int overlap = 0, start_w = 0, start_wmax = 0, cyc = 0, hi_run = 0;
    logic [N-1:0] prev_cs = '1;

    initial begin
        for (int i = 0; i < N; i++) cs_falls[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    grant_q.push_back(i);
                    grant_cyc.push_back(cyc);
                end
                if (bus.rsp_valid[i]) begin
                    rsp_idx.push_back(i);
                    rsp_dat.push_back(int'(bus.rsp_data));
                    rsp_er.push_back(int'(bus.rsp_err));
                    rsp_cyc.push_back(cyc);
                    rsp_cs.push_back(int'(cs_n));
                end
                if (prev_cs[i] && !cs_n[i]) cs_falls[i]++;
            end
            if (spi_start) begin
                tx_q.push_back(int'(spi_tx));
                start_cyc.push_back(cyc);
                start_w++;
                if (start_w > start_wmax) start_wmax = start_w;
            end else begin
                start_w = 0;
            end
            if ($countones(~cs_n) > 1) overlap++;
            if (&cs_n) begin
                hi_run++;
            end else begin
                if (&prev_cs) gap_runs.push_back(hi_run);
                hi_run = 0;
            end
            prev_cs = cs_n;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_rsp(int target, int budget);
        int k = 0;
        while (rsp_idx.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rsp_idx.size() < target) check("wait_rsp_timeout", rsp_idx.size(), target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int pack_grants(int base, int n);
        int v = 0;
        for (int k = 0; k < n; k++) v = (v << 4) | (qi(grant_q, base + k) & 15);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed tests ----------------
    initial begin
        int g0, r0, t0, gr0, f2, k;

        // Reset values
        #3 rst_n = 1'b0;
        #1;
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_spi_tx", spi_tx, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte: req 1 sends 0xA5, engine returns 0x3C
        g0 = grant_q.size(); r0 = rsp_idx.size(); t0 = tx_q.size();
        push(1, 8'hA5, 1'b1);
        wait_rsp(r0 + 1, 60);
        repeat (6) @(negedge clk);
        check("single_grant_count", grant_q.size() - g0, 1);
        check("single_grant_idx", qi(grant_q, g0), 1);
        check("single_tx", qi(tx_q, t0), 8'hA5);
        check("single_start_after_ready", qi(start_cyc, t0) - qi(grant_cyc, g0), 1);
        check("single_rsp_idx", qi(rsp_idx, r0), 1);
        check("single_rsp_data", qi(rsp_dat, r0), 8'h3C);
        check("single_rsp_err", qi(rsp_er, r0), 0);
        // busy 3 cycles after strobe, low in the 4th, response in the 5th
        check("single_rsp_latency", qi(rsp_cyc, r0) - qi(start_cyc, t0), 5);

        // Round robin from pointer 0
        do_reset();
        g0 = grant_q.size(); r0 = rsp_idx.size(); gr0 = gap_runs.size();
        push(0, 8'h10, 1'b1);
        push(1, 8'h21, 1'b1);
        push(2, 8'h32, 1'b1);
        push(3, 8'h43, 1'b1);
        push(0, 8'h54, 1'b1);
        wait_rsp(r0 + 5, 300);
        check("rr_order", pack_grants(g0, 5), 32'h01230);
        check("rr_rsp3_data", qi(rsp_dat, r0 + 3), 8'hDA);
        check("rr_rsp4_data", qi(rsp_dat, r0 + 4), 8'hCD);
        // GAP_CYCLES high cycles plus the IDLE sampling cycle
        check("rr_gap_first", qi(gap_runs, gr0 + 1), 3);
        check("rr_gap_last", qi(gap_runs, gr0 + 4), 3);

        // Locked burst on req 2 while req 0 requests
        do_reset();
        g0 = grant_q.size(); r0 = rsp_idx.size(); gr0 = gap_runs.size(); f2 = cs_falls[2];
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        k = 0;
        while (grant_q.size() <= g0 && k < 20) begin @(negedge clk); k++; end
        push(0, 8'h5A, 1'b1);
        wait_rsp(r0 + 4, 300);
        check("burst_order", pack_grants(g0, 4), 32'h2220);
        check("burst_cs2_single_fall", cs_falls[2] - f2, 1);
        check("burst_rsp0_data", qi(rsp_dat, r0), 8'h88);
        check("burst_rsp2_data", qi(rsp_dat, r0 + 2), 8'hAA);
        check("burst_req0_data", qi(rsp_dat, r0 + 3), 8'hC3);
        check("burst_req0_after_burst", qi(grant_cyc, g0 + 3) > qi(rsp_cyc, r0 + 2), 1);
        check("burst_gap_before_req0", qi(gap_runs, gr0 + 1), 3);

        // Start timeout: engine never goes busy
        do_reset();
        eng_mode = 1;
        r0 = rsp_idx.size(); t0 = tx_q.size();
        push(3, 8'h77, 1'b1);
        wait_rsp(r0 + 1, 60);
        check("stto_idx", qi(rsp_idx, r0), 3);
        check("stto_err", qi(rsp_er, r0), 1);
        check("stto_data", qi(rsp_dat, r0), 0);
        // four WAIT_BUSY cycles after the strobe, then the error pulse
        check("stto_latency", qi(rsp_cyc, r0) - qi(start_cyc, t0), 5);
        check("stto_cs_released", qi(rsp_cs, r0), 4'hF);
        eng_mode = 0;
        repeat (6) @(negedge clk);

        // Transfer timeout: spi_en stuck high, pointer moves to owner+1
        do_reset();
        eng_mode = 2;
        g0 = grant_q.size(); r0 = rsp_idx.size(); t0 = tx_q.size();
        push(1, 8'h66, 1'b1);
        wait_rsp(r0 + 1, 200);
        check("xfto_idx", qi(rsp_idx, r0), 1);
        check("xfto_err", qi(rsp_er, r0), 1);
        check("xfto_data", qi(rsp_dat, r0), 0);
        // one WAIT_BUSY cycle, 64 WAIT_DONE cycles, response next cycle
        check("xfto_latency", qi(rsp_cyc, r0) - qi(start_cyc, t0), 66);
        eng_mode = 0;
        repeat (6) @(negedge clk);
        push(1, 8'h01, 1'b1);
        push(2, 8'h02, 1'b1);
        wait_rsp(r0 + 3, 200);
        check("xfto_next_grant", qi(grant_q, g0 + 1), 2);
        check("xfto_then_grant", qi(grant_q, g0 + 2), 1);
        check("xfto_next_ok", qi(rsp_er, r0 + 1), 0);

        // Reset during WAIT_DONE
        do_reset();
        eng_mode = 2;
        push(2, 8'h44, 1'b1);
        k = 0;
        while (!spi_en && k < 20) begin @(negedge clk); k++; end
        repeat (5) @(posedge clk);
        #2;
        check("rstmid_pre_cs", cs_n, 4'b1011);
        r0 = rsp_idx.size();
        rst_n = 1'b0;
        #1;
        check("rstmid_cs_n", cs_n, 4'hF);
        check("rstmid_req_ready", bus.req_ready, 0);
        check("rstmid_rsp_valid", bus.rsp_valid, 0);
        check("rstmid_rsp_err", bus.rsp_err, 0);
        check("rstmid_spi_start", spi_start, 0);
        eng_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstmid_no_rsp", rsp_idx.size() - r0, 0);
        g0 = grant_q.size();
        push(1, 8'h0A, 1'b1);
        push(3, 8'h0B, 1'b1);
        wait_rsp(r0 + 2, 200);
        check("rstmid_ptr0_order", pack_grants(g0, 2), 32'h13);

        // Whole-run invariants
        check("cs_n_overlap", overlap, 0);
        check("spi_start_width", start_wmax, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
